// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Also holds the RV32 major opcodes so that decode can reuse them.
package fetch_pkg;

    localparam int unsigned FETCH_W      = 32;
    localparam int unsigned FETCH_PC_LEN = 32;

    localparam logic [FETCH_PC_LEN-1:0] DEFAULT_RESET_PC   = '0;
    localparam logic [FETCH_W-1:0]      DEFAULT_HALT_INSTR = 32'h0010_0073;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [FETCH_PC_LEN-1:0] pc;
        logic [FETCH_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} entries; head is always the oldest entry.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t tail;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (do_push && do_pop) begin
            // Count is unchanged; a full queue shifts tail into head.
            if (count == 2'd2) begin
                head <= tail;
                tail <= din;
            end else begin
                head <= din;
            end
        end else if (do_push) begin
            if (count == 2'd0) begin
                head <= din;
            end else begin
                tail <= din;
            end
            count <= count + 2'd1;
        end else if (do_pop) begin
            if (count == 2'd2) begin
                head <= tail;
            end
            count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational ins_mem and feeds decode
// through a 2-entry queue; handles redirect, halt on EBREAK and fetch faults.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       W          = 32,
    parameter int unsigned       PC_LEN     = 32,
    parameter int unsigned       IMEM_DEPTH = 128,
    parameter logic [PC_LEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [W-1:0]      HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [PC_LEN-1:0] imem_addr,
    input  logic [W-1:0]      imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_LEN-1:0] out_pc,
    output logic [W-1:0]      out_instr,
    input  logic              redirect_valid,
    input  logic [PC_LEN-1:0] redirect_pc,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    localparam logic [PC_LEN:0] PC_LIMIT = (PC_LEN + 1)'(IMEM_DEPTH * 4);

    logic [PC_LEN-1:0] pc;
    logic [1:0]        count;
    fetch_entry_t      head;
    fetch_entry_t      din;
    logic              pc_ok;
    logic              deq;
    logic              can_fetch;
    logic              push;

    assign imem_addr = pc;
    assign pc_ok     = (pc[1:0] == 2'b00) && ({1'b0, pc} < PC_LIMIT);
    assign deq       = out_valid && out_ready;
    assign can_fetch = fetch_en && !halted && !fault && pc_ok
                       && ((count != 2'd2) || deq);
    assign push      = can_fetch && !redirect_valid;

    assign din.pc    = pc;
    assign din.instr = imem_instr;

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (deq && !redirect_valid),
        .flush (redirect_valid),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign out_valid = (count != 2'd0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            if (push) begin
                pc          <= pc + PC_LEN'(4);
                fetch_count <= fetch_count + 32'd1;
                if (imem_instr == HALT_INSTR) begin
                    halted <= 1'b1;
                end
            end
            if (fetch_en && !halted && !pc_ok) begin
                fault <= 1'b1;
            end
        end
    end

    head_stable_a: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_pc) && $stable(out_instr))
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model of the fetch rules.
module tb_inst_fetch_unit;

    localparam logic [31:0] HALT = 32'h0010_0073;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:127];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_h;
    bit          m_f;
    ent_t        m_q[$];

    inst_fetch_unit #(
        .W          (32),
        .PC_LEN     (32),
        .IMEM_DEPTH (128),
        .RESET_PC   (32'h0),
        .HALT_INSTR (HALT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = (imem_addr < 32'd512) ? mem[imem_addr[8:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memrd(input logic [31:0] a);
        logic [6:0] idx;
        idx = a[8:2];
        return (a < 32'd512) ? mem[idx] : 32'hDEAD_BEEF;
    endfunction

    // Advance the model by one clock edge using the current inputs, then the DUT.
    task automatic tick();
        bit   dq, ok, can, h0;
        ent_t e;
        dq  = (m_q.size() != 0) && out_ready;
        ok  = (m_pc[1:0] == 2'b00) && (m_pc < 32'd512);
        can = fetch_en && !m_h && !m_f && ok && ((m_q.size() < 2) || dq);
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc;
            m_h  = 0;
            m_f  = 0;
        end else begin
            h0 = m_h;
            if (dq) void'(m_q.pop_front());
            if (can) begin
                e.pc    = m_pc;
                e.instr = memrd(m_pc);
                m_q.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
                if (e.instr == HALT) m_h = 1;
            end
            if (fetch_en && !h0 && !ok) m_f = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        m_pc  = '0;
        m_cnt = '0;
        m_h   = 0;
        m_f   = 0;
        m_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_checks++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
            n_fail++; $display("FAIL reset_head: got pc %h instr %h want 0 0", out_pc, out_instr);
        end
        n_checks++;
        if (halted !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got h %0b f %0b cnt %0d want 0 0 0", halted, fault, fetch_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (imem_addr !== 32'(i * 4)) begin
                n_fail++; $display("FAIL stream_addr %0d: got %h want %h", i, imem_addr, 32'(i * 4));
            end
            tick();
            if (i == 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin
                    n_fail++;
                    $display("FAIL stream_first: got v %0b pc %h instr %h want 1 0 10000000", out_valid, out_pc, out_instr);
                end
            end
        end
        n_checks++;
        if (fetch_count !== 32'd16) begin n_fail++; $display("FAIL stream_count: got %0d want 16", fetch_count); end
        n_checks++;
        if (out_pc !== m_q[0].pc || out_instr !== m_q[0].instr) begin
            n_fail++; $display("FAIL stream_head: got %h/%h want %h/%h", out_pc, out_instr, m_q[0].pc, m_q[0].instr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_stall: got addr %h pc %h v %0b want 8 0 1", imem_addr, out_pc, out_valid);
        end
        n_checks++;
        if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", fetch_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL bp_drain %0d: got v %0b pc %h instr %h want 1 %h %h", i, out_valid, out_pc, out_instr, 32'(i * 4), 32'h1000_0000 + 32'(i));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL redir_flush: got v %0b addr %h want 0 40", out_valid, imem_addr);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1000_0010) begin
            n_fail++; $display("FAIL redir_target: got v %0b pc %h instr %h want 1 40 10000010", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_halt();
        logic [31:0] got[$];
        mem[5] = HALT;
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) got.push_back(out_pc);
            tick();
        end
        n_checks++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL halt_n_delivered: got %0d want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL halt_order %0d: got %h want %h", i, got[i], 32'(i * 4)); end
            end
        end
        n_checks++;
        if (halted !== 1'b1 || imem_addr !== 32'd24 || fetch_count !== 32'd6) begin
            n_fail++; $display("FAIL halt_state: got h %0b addr %h cnt %0d want 1 18 6", halted, imem_addr, fetch_count);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %0b want 0", halted); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL halt_resume: got v %0b pc %h addr %h want 1 0 4", out_valid, out_pc, imem_addr);
        end
        mem[5] = 32'h1000_0005;
    endtask

    task automatic test_fault();
        logic [31:0] targets[2];
        logic [31:0] cnt0;
        targets[0] = 32'h200;
        targets[1] = 32'h6;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            fetch_en = 1'b1; out_ready = 1'b1;
            tick(); tick();
            redirect_valid = 1'b1; redirect_pc = targets[t];
            tick();
            redirect_valid = 1'b0;
            cnt0 = fetch_count;
            n_checks++;
            if (fault !== 1'b0 || imem_addr !== targets[t]) begin
                n_fail++; $display("FAIL fault_pre %0d: got f %0b addr %h want 0 %h", t, fault, imem_addr, targets[t]);
            end
            tick();
            n_checks++;
            if (fault !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL fault_set %0d: got f %0b v %0b want 1 0", t, fault, out_valid);
            end
            tick();
            n_checks++;
            if (fetch_count !== cnt0 || out_valid !== 1'b0 || imem_addr !== targets[t]) begin
                n_fail++; $display("FAIL fault_hold %0d: got cnt %0d v %0b addr %h want %0d 0 %h", t, fetch_count, out_valid, imem_addr, cnt0, targets[t]);
            end
            redirect_valid = 1'b1; redirect_pc = 32'h0;
            tick();
            redirect_valid = 1'b0;
            n_checks++;
            if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear %0d: got %0b want 0", t, fault); end
        end
    endtask

    task automatic test_random();
        int unsigned r;
        for (int i = 0; i < 128; i++) mem[i] = ($urandom_range(0, 99) < 3) ? HALT : $urandom;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            fetch_en  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 9);
            if (r < 7)       redirect_pc = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
            else if (r == 7) redirect_pc = 32'h200 + {$urandom_range(0, 15), 2'b00};
            else if (r == 8) redirect_pc = {23'h0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
            else             redirect_pc = 32'd504;
            tick();
            n_checks++;
            if (out_valid !== (m_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid cyc %0d: got %0b want %0b", c, out_valid, m_q.size() != 0);
            end else if (m_q.size() != 0) begin
                n_checks++;
                if (out_pc !== m_q[0].pc || out_instr !== m_q[0].instr) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d: got %h/%h want %h/%h", c, out_pc, out_instr, m_q[0].pc, m_q[0].instr);
                end
            end
            n_checks++;
            if (imem_addr !== m_pc || halted !== m_h || fault !== m_f || fetch_count !== m_cnt) begin
                n_fail++;
                $display("FAIL rnd_state cyc %0d: got addr %h h %0b f %0b cnt %0d want %h %0b %0b %0d", c, imem_addr, halted, fault, fetch_count, m_pc, m_h, m_f, m_cnt);
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (out_valid !== 1'b1 || fetch_count !== 32'd2) begin
            n_fail++; $display("FAIL rstmid_pre: got v %0b cnt %0d want 1 2", out_valid, fetch_count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v %0b addr %h cnt %0d h %0b f %0b want 0 0 0 0 0", out_valid, imem_addr, fetch_count, halted, fault);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
